// File: rtl/div_ctrl.sv
// Sequencing controller for the execute-stage iterative 32-bit divider.
// Restoring shift-subtract with sign fix-up, signed and unsigned, en/done handshake.
module div_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_flush,
  input  logic             is_stall,
  input  logic             en,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(ITER);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  // Bit 32 of the partial remainder is provably zero after every step, so only 32 bits are kept.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qNeg_q, qNeg_d;
  logic             rNeg_q, rNeg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remOut_q, remOut_d;
  logic [WIDTH:0]   trial;

  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    qNeg_d   = qNeg_q;
    rNeg_d   = rNeg_q;
    quot_d   = quot_q;
    remOut_d = remOut_q;
    trial    = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};

    // Flush wins over a same-cycle start and over leaving DONE.
    if (is_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en) begin
            if (divisor == '0) begin
              quot_d   = '1;
              remOut_d = dividend;
              state_d  = S_DONE;
            end else begin
              dvd_d   = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
              dvs_d   = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
              qNeg_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              rNeg_d  = is_signed & dividend[WIDTH-1];
              rem_d   = '0;
              cnt_d   = CW'(ITER - 1);
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} : trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
          if (cnt_q == '0) begin
            state_d = S_FIXUP;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_FIXUP: begin
          quot_d   = qNeg_q ? -dvd_q : dvd_q;
          remOut_d = rNeg_q ? -rem_q : rem_q;
          state_d  = S_DONE;
        end
        S_DONE: begin
          if (!is_stall) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      qNeg_q   <= 1'b0;
      rNeg_q   <= 1'b0;
      quot_q   <= '0;
      remOut_q <= '0;
    end else begin
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      qNeg_q   <= qNeg_d;
      rNeg_q   <= rNeg_d;
      quot_q   <= quot_d;
      remOut_q <= remOut_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = remOut_q;
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_FIXUP);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: expected quotient/remainder pairs are queued at
// start and popped when done rises; latency, handshake, flush, stall and reset are checked.
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        is_flush;
  logic        is_stall;
  logic        en;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;
  logic        busy;

  int          nCompared;
  int          nMismatched;
  logic [63:0] expQueue[$];

  div_ctrl #(.WIDTH(32), .ITER(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .is_flush  (is_flush),
    .is_stall  (is_stall),
    .en        (en),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Moves into a fresh cycle (cycle 0), drives a start and queues its expected result.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expQ, input logic [31:0] expR, input string tag);
    tick();
    checkOutput({tag, " idle-done"}, {31'd0, done}, 32'd0);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    en        = 1'b1;
    expQueue.push_back({expQ, expR});
  endtask

  // Waits (bounded) for done, checks latency and busy profile, pops and compares the result.
  task automatic waitDone(input int expLat, input string tag, input bit dropEn);
    int          lat;
    bit          seen;
    bit          busyOk;
    logic [63:0] expPair;
    lat    = 0;
    seen   = 0;
    busyOk = 1;
    while (!seen && lat < 100) begin
      tick();
      lat++;
      if (dropEn) en = 1'b0;
      if (done === 1'b1) seen = 1;
      else if (busy !== 1'b1) busyOk = 0;
    end
    en = 1'b0;
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, " busy-while-running"}, {31'd0, busyOk}, 32'd1);
    checkOutput({tag, " busy-in-done"}, {31'd0, busy}, 32'd0);
    if (expQueue.size() > 0) expPair = expQueue.pop_front();
    else expPair = '1;
    checkOutput({tag, " quotient"}, quotient, expPair[63:32]);
    checkOutput({tag, " remainder"}, remainder, expPair[31:0]);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rq;
    logic [31:0] rr;
    logic        rs;
    bit          quiet;

    nCompared   = 0;
    nMismatched = 0;
    rst = 1'b1; is_flush = 1'b0; is_stall = 1'b0; en = 1'b0;
    is_signed = 1'b0; dividend = '0; divisor = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("reset quotient", quotient, 32'd0);
    checkOutput("reset remainder", remainder, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);

    applyStimulus(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "u100/7");
    waitDone(34, "u100/7", 1'b0);

    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "s-7/2");
    waitDone(34, "s-7/2", 1'b1);
    applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, "s7/-2");
    waitDone(34, "s7/-2", 1'b1);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, "uMax/1");
    waitDone(34, "uMax/1", 1'b1);
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "sOverflow");
    waitDone(34, "sOverflow", 1'b1);
    applyStimulus(1'b1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, "div0");
    waitDone(1, "div0", 1'b1);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == 32'd0) rb = 32'd3;
      rs = i[0];
      if (rs && rb == 32'hFFFF_FFFF) rb = 32'd5;
      if (rs) begin
        rq = $signed(ra) / $signed(rb);
        rr = $signed(ra) % $signed(rb);
      end else begin
        rq = ra / rb;
        rr = ra % rb;
      end
      applyStimulus(rs, ra, rb, rq, rr, "random");
      waitDone(34, "random", 1'b1);
    end

    // Flush in cycle 10 aborts; restart in cycle 11 lands done in cycle 45.
    tick();
    is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; en = 1'b1;
    quiet = 1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      en = 1'b0;
      if (done !== 1'b0 || busy !== 1'b1) quiet = 0;
    end
    is_flush = 1'b1;
    tick();
    is_flush = 1'b0;
    checkOutput("flush pre-abort profile", {31'd0, quiet}, 32'd1);
    checkOutput("flush done", {31'd0, done}, 32'd0);
    checkOutput("flush busy", {31'd0, busy}, 32'd0);
    dividend = 32'd50; divisor = 32'd5; en = 1'b1;
    expQueue.push_back({32'd10, 32'd0});
    waitDone(34, "flushRestart", 1'b1);

    // Stall holds DONE for cycles 34-36; operands scrambled mid-run must not matter.
    applyStimulus(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "stall");
    tick();
    en = 1'b0; is_signed = 1'b1; dividend = 32'hDEAD_BEEF; divisor = 32'd3;
    waitDone(33, "stall", 1'b1);
    is_stall = 1'b1;
    for (int c = 35; c <= 36; c++) begin
      tick();
      checkOutput("stall hold done", {31'd0, done}, 32'd1);
      checkOutput("stall hold quotient", quotient, 32'd14);
      checkOutput("stall hold remainder", remainder, 32'd2);
    end
    tick();
    is_stall = 1'b0;
    checkOutput("stall cycle37 done", {31'd0, done}, 32'd1);
    tick();
    checkOutput("stall cycle38 done", {31'd0, done}, 32'd0);

    // en and flush together in IDLE: nothing starts.
    tick();
    en = 1'b1; is_flush = 1'b1; is_signed = 1'b0; dividend = 32'd5; divisor = 32'd1;
    tick();
    en = 1'b0; is_flush = 1'b0;
    checkOutput("enFlush busy", {31'd0, busy}, 32'd0);
    checkOutput("enFlush done", {31'd0, done}, 32'd0);
    tick();
    checkOutput("enFlush stays idle", {31'd0, busy}, 32'd0);

    // Reset mid-RUN clears state and outputs.
    tick();
    is_signed = 1'b0; dividend = 32'hFFFF_FFFF; divisor = 32'd1; en = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      en = 1'b0;
    end
    checkOutput("preReset busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midRunReset quotient", quotient, 32'd0);
    checkOutput("midRunReset remainder", remainder, 32'd0);
    checkOutput("midRunReset done", {31'd0, done}, 32'd0);
    checkOutput("midRunReset busy", {31'd0, busy}, 32'd0);

    checkOutput("scoreboard drained", 32'(expQueue.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller for the execute stage's iterative 32-bit integer divider, covering signed and unsigned quotient and remainder. It captures operands on a start request and runs a fixed 32-iteration restoring shift-subtract sequence. It then applies sign fix-up and holds the result under pipeline stall. It sits beside the ALU/BRU in execute and speaks the en/done handshake the stage already uses (stage drives en = is_div & ~done and stalls on is_div & ~done).

## Interface
Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- ITER, 32, iterations per division; must equal WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- is_flush  in  1  pipeline flush; aborts any operation
- is_stall  in  1  downstream stall; holds a finished result
- en  in  1  start request; sampled only in IDLE
- is_signed  in  1  1 = two's-complement operands (div.w/mod.w), 0 = unsigned
- dividend  in  32  rj operand
- divisor  in  32  rk operand
- quotient  out  32  result quotient; valid while done
- remainder  out  32  result remainder; valid while done
- done  out  1  result valid
- busy  out  1  high in RUN or FIXUP

## Operation
- States: IDLE, RUN, FIXUP, DONE.
- IDLE:
  - en=1 and divisor==0: latch quotient=32'hFFFF_FFFF, remainder=dividend, go to DONE.
  - en=1 and divisor!=0: latch |dividend| and |divisor| (abs only when is_signed), q_neg = is_signed & (dividend[31]^divisor[31]), r_neg = is_signed & dividend[31]; clear the 33-bit partial remainder; load iteration counter = ITER-1; go to RUN.
- RUN, one iteration per cycle:
  - trial = {rem[31:0], dvd[31]} - {1'b0, dvs}, 33-bit.
  - trial[32]==0: rem = trial, shifted-in quotient bit = 1; otherwise rem = {rem[31:0], dvd[31]}, bit = 0.
  - dvd shifts left, with the quotient bit entering at bit 0.
  - Counter decrements; at 0, go to FIXUP.
- FIXUP: quotient = q_neg ? -dvd : dvd; remainder = r_neg ? -rem[31:0] : rem[31:0]; go to DONE.
- DONE: done=1. Stay while is_stall=1; go to IDLE next cycle when is_stall=0. quotient/remainder stay stable until the next start.
- Operand inputs and en are ignored outside IDLE; a new start needs a pass through IDLE.
- Overflow case 0x8000_0000 / 0xFFFF_FFFF (signed) needs no special path: it yields q=0x8000_0000, r=0.
- Flush or reset in any state: next state IDLE, done=0, busy=0, no result produced.
  - Flush beats a same-cycle en and a same-cycle DONE exit.
  - quotient/remainder registers need not clear on flush.
- is_stall does not affect RUN/FIXUP progress.

## Timing
- Reset values: state IDLE, done 0, busy 0, quotient 0, remainder 0, counter 0.
- Cycle 0 is the cycle en is sampled high in IDLE.
  - Normal divide: RUN in cycles 1–32, FIXUP in cycle 33, done=1 in cycle 34. Latency is 34 cycles, independent of operands and signedness.
  - Divide by zero: done=1 in cycle 1.
- done is a registered state decode, with no combinational path from inputs.
- Back-to-back: done in cycle N with is_stall=0, so the stage advances and state is IDLE in N+1. en in N+1 starts the next divide, whose done lands in N+35.
- Flush in cycle k: done=0 from k+1. en in k+1 starts a fresh full-latency operation.
- Reset mid-RUN behaves exactly like flush, and also clears the outputs.

## Test plan
- Unsigned 100/7, en held until done → done first high in cycle 34 with q=14, r=2; busy high in cycles 1–33.
- Signed -7/2 (0xFFFF_FFF9 / 2) → q=0xFFFF_FFFD, r=0xFFFF_FFFF. Signed 7/-2 → q=0xFFFF_FFFD, r=1. Unsigned 0xFFFF_FFFF/1 → q=0xFFFF_FFFF, r=0.
- Signed 0x8000_0000/0xFFFF_FFFF → q=0x8000_0000, r=0. Any /0 (dividend 0x1234) → done in cycle 1, q=0xFFFF_FFFF, r=0x1234.
- Start 100/7, assert is_flush in cycle 10 → done never rises. en in cycle 11 with 50/5 → done in cycle 45, q=10, r=0.
- Finish 100/7 with is_stall=1 in cycles 34–36 → done and outputs hold 14/2 through cycle 36; done=0 in cycle 38. Operand changes during RUN do not affect the result.
- en and is_flush high in the same IDLE cycle → state stays IDLE, busy=0. Reset asserted mid-RUN → all outputs read 0 the next cycle.
